l1_dcache_ctrl: RTL and testbench
=================================

L1_DCACHE_CTRL -- requirements
Module: l1_dcache_ctrl

Interface
REQ-001 SHALL take parameter NUM_LINES, default 16: number of direct-mapped lines, a power of 2.
REQ-002 SHALL take parameter WORDS_PER_LINE, default 4: 32-bit words per line, a power of 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports cpu_rd and cpu_wr, input, 1 bit each: MEM-stage load and store request.
REQ-006 SHALL have ports cpu_addr and cpu_wdata, input, 32 bits each: byte address and store data.
REQ-007 SHALL have port cpu_rdata, output, 32 bits: load data.
REQ-008 SHALL have port cpu_stall, output, 1 bit: freeze the pipeline while asserted.
REQ-009 SHALL have ports mem_req and mem_we, output, 1 bit each: backing-dmem request and write enable.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, 32 bits each: word-aligned address and write data.
REQ-011 SHALL have port mem_rdata, input, 32 bits: backing-dmem read data.
REQ-012 SHALL have port mem_ack, input, 1 bit: completes one word transfer, either read or write.

Function
REQ-013 SHALL split cpu_addr into byte offset [1:0] (ignored), word offset, index and tag (remaining upper bits); defaults: word [3:2], index [7:4], tag [31:8].
REQ-014 SHALL use FSM states IDLE, FILL and WRITE.
REQ-015 On a read hit in IDLE (valid and tag equal), SHALL drive cpu_rdata combinationally in the same cycle with cpu_stall=0.
REQ-016 On a read miss in IDLE, SHALL raise cpu_stall combinationally, enter FILL, and latch the line base address.
REQ-017 In FILL, SHALL hold mem_req=1 and mem_we=0, with mem_addr = line base + 4*word counter.
REQ-018 In FILL, each mem_ack SHALL store mem_rdata into the counted word and increment the counter.
REQ-019 On the ack of the last word, SHALL set valid, write the tag and return to IDLE; the retried load then hits the following cycle, so miss penalty = WORDS_PER_LINE acks + 1 cycle.
REQ-020 Writes SHALL be write-through with no write-allocate: a store in IDLE enters WRITE with mem_req=1, mem_we=1, mem_addr=cpu_addr & ~3 and mem_wdata=cpu_wdata.
REQ-021 In WRITE, cpu_stall SHALL stay 1 until mem_ack; on ack, a store hit SHALL also update the cached word, then return to IDLE, making the store one cycle plus memory latency.
REQ-022 A store miss SHALL leave the cache contents unchanged.
REQ-023 If cpu_rd and cpu_wr are both 1, the request SHALL be treated as a store.
REQ-024 mem_ack SHALL be ignored in IDLE.
REQ-025 cpu_addr and cpu_wdata SHALL be assumed stable while cpu_stall=1; the block SHALL use its latched copies.
REQ-026 The fill word counter SHALL wrap to 0 after the last word.
REQ-027 cpu_stall SHALL be 0 in IDLE when neither cpu_rd nor cpu_wr is asserted.

Reset
REQ-028 While reset=0 at a clock edge: state=IDLE, all valid bits=0, counter=0, and mem_req, mem_we and cpu_stall=0 from the next cycle.
REQ-029 Reset during FILL or WRITE SHALL abort the transfer, leaving the partially filled line invalid; a late mem_ack is ignored.
REQ-030 Data and tag arrays SHALL NOT require reset; cpu_rdata SHALL be 0 whenever there is no read hit.

Configuration
REQ-031 With DCACHE_STATS_EN defined, SHALL add outputs hit_cnt and miss_cnt, 32 bits each, reset to 0.
REQ-032 With DCACHE_STATS_EN defined, each counter SHALL increment once per completed access: a read or write hit, or a read or write miss.
REQ-033 With DCACHE_STATS_EN defined, the counters SHALL wrap at 2^32.
REQ-034 Without DCACHE_STATS_EN, the ports and counter logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the default NUM_LINES and WORDS_PER_LINE, and the derived offset, index and tag width constants.
REQ-036 Tag, valid and data storage SHALL live in one sub-module, dcache_array, with a synchronous write port and an asynchronous read port.

Verification
REQ-037 Cold read 0x80, memory ack latency 2 -> 4 fill reads at 0x80, 0x84, 0x88 and 0x8C, cpu_stall high for 9 cycles, then cpu_rdata equals memory word 0x80.
REQ-038 Read 0x84 right after that fill -> cpu_stall=0 and data valid in the same cycle, with no mem_req.
REQ-039 Store 0xDEAD at 0x80 (hit), then read 0x80 -> one mem write carrying 0x0000DEAD, and the read hits returning 0x0000DEAD; store to 0x200 (miss), then read 0x200 -> fill occurs.
REQ-040 Conflict: read 0x80, then read 0x180 (same index, different tag), then read 0x80 -> three fills, with the second evicting the first.
REQ-041 Assert reset=0 after the 2nd ack of a fill, then re-read the same address -> full 4-word fill restarts, and no stale hit occurs.
REQ-042 With DCACHE_STATS_EN defined, run scenarios REQ-037 and REQ-038 -> hit_cnt=2, miss_cnt=1.

Source files
------------

// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared types and geometry constants for the L1 data cache controller.
// The default-geometry constants below mirror the parameter defaults of the top.
package l1_dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    localparam int WORD_W   = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int OFFSET_W = WORD_W + 2;
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

endpackage

// File: rtl/l1_dcache_ctrl_array.sv
// Tag, valid and data storage for the direct-mapped cache: synchronous writes,
// asynchronous reads. Only the valid bits are reset.
module dcache_array #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 4,
    parameter int WRD_W          = 2,
    parameter int TG_W           = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    input  logic [WRD_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TG_W-1:0]  rd_tag,
    output logic [31:0]      rd_data,
    input  logic             data_we,
    input  logic [WRD_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic             tag_inv,
    input  logic [TG_W-1:0]  wr_tag
);

    logic [NUM_LINES-1:0] valid;
    logic [TG_W-1:0]      tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (!reset)
            valid <= '0;
        else if (tag_we)
            valid[index] <= 1'b1;
        else if (tag_inv)
            valid[index] <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (tag_we)
            tags[index] <= wr_tag;
        if (data_we)
            data[{index, wr_word}] <= wr_data;
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tags[index];
    assign rd_data  = data[{index, rd_word}];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Define DCACHE_STATS_EN to add the hit_cnt / miss_cnt statistics outputs.
module l1_dcache_ctrl import l1_dcache_ctrl_pkg::*; #(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WRD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = WRD_W + 2;
    localparam int TG_W  = 32 - OFF_W - IDX_W;

    state_t             state;
    logic [31:2]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [WRD_W-1:0]   cnt;
    logic [31:2]        addr_sel;
    logic               rd_valid, hit, is_rd, rd_hit, rd_miss, last;
    logic               fill_ack, wr_ack;
    logic [TG_W-1:0]    rd_tag;
    logic [31:0]        rd_data;
    logic               unused_bits;

    assign unused_bits = ^cpu_addr[1:0];

    // Outside IDLE the pipeline is frozen, so the latched address drives lookup.
    assign addr_sel = (state == IDLE) ? cpu_addr[31:2] : lat_addr;
    assign hit      = rd_valid && (rd_tag == addr_sel[31 -: TG_W]);
    assign is_rd    = cpu_rd && !cpu_wr;
    assign rd_hit   = (state == IDLE) && is_rd && hit;
    assign rd_miss  = (state == IDLE) && is_rd && !hit;
    assign last     = (cnt == WRD_W'(WORDS_PER_LINE - 1));
    assign fill_ack = (state == FILL) && mem_ack;
    assign wr_ack   = (state == WRITE) && mem_ack;

    dcache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .WRD_W          (WRD_W),
        .TG_W           (TG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .index    (addr_sel[OFF_W +: IDX_W]),
        .rd_word  (addr_sel[2 +: WRD_W]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (fill_ack || (wr_ack && hit)),
        .wr_word  ((state == FILL) ? cnt : addr_sel[2 +: WRD_W]),
        .wr_data  ((state == FILL) ? mem_rdata : lat_wdata),
        .tag_we   (fill_ack && last),
        .tag_inv  (rd_miss),
        .wr_tag   (addr_sel[31 -: TG_W])
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        state     <= WRITE;
                        lat_addr  <= cpu_addr[31:2];
                        lat_wdata <= cpu_wdata;
                    end else if (rd_miss) begin
                        state    <= FILL;
                        lat_addr <= cpu_addr[31:2];
                        cnt      <= '0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last)
                            state <= IDLE;
                    end
                end
                WRITE: if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A store releases the pipeline in its ack cycle; a load miss stalls
    // through the last ack and completes as a hit on the retry.
    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            IDLE:    cpu_stall = cpu_wr || (cpu_rd && !hit);
            FILL:    cpu_stall = 1'b1;
            WRITE:   cpu_stall = !mem_ack;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign cpu_rdata = rd_hit ? rd_data : 32'h0;
    assign mem_req   = (state == FILL) || (state == WRITE);
    assign mem_we    = (state == WRITE);
    assign mem_wdata = (state == WRITE) ? lat_wdata : 32'h0;
    assign mem_addr  = (state == FILL)  ? {lat_addr[31:OFF_W], cnt, 2'b00} :
                       (state == WRITE) ? {lat_addr, 2'b00} : 32'h0;

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (rd_hit || (wr_ack && hit))
                hit_cnt <= hit_cnt + 1'b1;
            if (rd_miss || (wr_ack && !hit))
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: table of CPU accesses with expected
// data/stall, plus a scoreboard of expected backing-memory transfers.
module tb_l1_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    l1_dcache_ctrl dut (
        .clk       (clk),
        .reset     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // Backing memory: each transfer acks in the second cycle of its request.
    logic [31:0] mem [256];
    int          lat;

    function automatic logic [31:0] memval(logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    assign mem_ack   = mem_req && (lat == 1);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!rst_n || !mem_req) begin
            lat <= 0;
        end else begin
            lat <= mem_ack ? 0 : lat + 1;
            if (mem_ack && mem_we)
                mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];

    always @(negedge clk)
        if (rst_n && mem_ack)
            obs_q.push_back('{mem_we, mem_addr, mem_wdata});

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        bit          fill;
        bit          wtxn;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[15];

    function automatic vec_t mk(string n, logic r, logic w, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, int es, bit f, bit wt);
        vec_t v;
        v.name = n; v.rd = r; v.wr = w; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_stall = es; v.fill = f; v.wtxn = wt;
        return v;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_fill(logic [31:0] a, int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{1'b0, (a & ~32'hF) + 32'(4 * k), 32'h0});
    endtask

    task automatic check_txns(string name);
        txn_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL %s txn: got none, expected addr %h we %0d", name, e.addr, e.we);
                continue;
            end
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                fails++;
                $display("FAIL %s txn: got we %0d addr %h data %h, expected we %0d addr %h data %h",
                         name, o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        check32({name, " extra txns"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    task automatic access(vec_t v);
        int          stalls = 0;
        bit          done = 0;
        logic [31:0] rdata = '0;
        if (v.fill) push_fill(v.addr, 4);
        if (v.wtxn) exp_q.push_back('{1'b1, v.addr & ~32'h3, v.wdata});
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done  = 1;
                rdata = cpu_rdata;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s timeout: stall still high after %0d cycles", v.name, stalls);
        end else begin
            check32({v.name, " stall"}, 32'(stalls), 32'(v.exp_stall));
            check32({v.name, " rdata"}, rdata, v.exp_rdata);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check_txns(v.name);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 256; i++) mem[i] <= memval(32'(i * 4));

        vecs[0]  = mk("cold rd 80",   1, 0, 32'h80,  0,       32'hC0DE0080, 9, 1, 0);
        vecs[1]  = mk("hit rd 84",    1, 0, 32'h84,  0,       32'hC0DE0084, 0, 0, 0);
        vecs[2]  = mk("st hit 80",    0, 1, 32'h80,  32'hDEAD, 32'h0,       2, 0, 1);
        vecs[3]  = mk("rd 80 upd",    1, 0, 32'h80,  0,       32'h0000DEAD, 0, 0, 0);
        vecs[4]  = mk("st miss 200",  0, 1, 32'h200, 32'h1234, 32'h0,       2, 0, 1);
        vecs[5]  = mk("rd 200 fill",  1, 0, 32'h200, 0,       32'h00001234, 9, 1, 0);
        vecs[6]  = mk("rd 180 evict", 1, 0, 32'h180, 0,       32'hC0DE0180, 9, 1, 0);
        vecs[7]  = mk("rd 80 refill", 1, 0, 32'h80,  0,       32'h0000DEAD, 9, 1, 0);
        vecs[8]  = mk("hit rd 88",    1, 0, 32'h88,  0,       32'hC0DE0088, 0, 0, 0);
        vecs[9]  = mk("rd+wr 8C",     1, 1, 32'h8C,  32'h55,  32'h0,        2, 0, 1);
        vecs[10] = mk("rd 8C",        1, 0, 32'h8C,  0,       32'h00000055, 0, 0, 0);
        vecs[11] = mk("rd 8E byteoff",1, 0, 32'h8E,  0,       32'h00000055, 0, 0, 0);
        vecs[12] = mk("hit rd 204",   1, 0, 32'h204, 0,       32'hC0DE0204, 0, 0, 0);
        vecs[13] = mk("st miss 180",  0, 1, 32'h180, 32'h77,  32'h0,        2, 0, 1);
        vecs[14] = mk("rd 80 kept",   1, 0, 32'h80,  0,       32'h0000DEAD, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset stall", {31'h0, cpu_stall}, 32'h0);
        check32("reset mem_req", {31'h0, mem_req}, 32'h0);
        check32("reset mem_we", {31'h0, mem_we}, 32'h0);
        check32("reset rdata", cpu_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check32("reset hit_cnt", hit_cnt, 32'h0);
        check32("reset miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            access(vecs[i]);
`ifdef DCACHE_STATS_EN
            if (i == 1) begin
                check32("stats hit_cnt", hit_cnt, 32'd2);
                check32("stats miss_cnt", miss_cnt, 32'd1);
            end
`endif
        end

        @(negedge clk);
        check32("idle stall", {31'h0, cpu_stall}, 32'h0);
        check32("idle mem_req", {31'h0, mem_req}, 32'h0);

        // Reset two acks into a fill; the line must refill from scratch afterwards.
        @(posedge clk); #1;
        push_fill(32'h300, 2);
        cpu_rd = 1'b1; cpu_addr = 32'h300;
        acks = 0;
        for (int c = 0; c < 40 && acks < 2; c++) begin
            @(negedge clk);
            if (mem_ack) acks++;
        end
        check32("abort acks seen", 32'(acks), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0; cpu_rd = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check32("abort mem_req", {31'h0, mem_req}, 32'h0);
        check32("abort stall", {31'h0, cpu_stall}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_txns("abort");
        @(posedge clk); #1;
        access(mk("rd 300 restart", 1, 0, 32'h300, 0, 32'hC0DE0300, 9, 1, 0));
        access(mk("rd 80 post-rst", 1, 0, 32'h80,  0, 32'h0000DEAD, 9, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
